// File: rtl/imem_bank.sv
// imem_bank: dual-port word memory (port A read/write with byte enables, port B read-only) that zeroes itself after reset.
// Latency: douta/doutb are registered one cycle after an enabled access; the clear sequence takes 2^ADDR_WIDTH cycles after reset.
// Backpressure: none; ready is low during clear, and accesses are ignored until it rises. Optional macro IMEM_BANK_FWD_EN forwards same-address port A write bytes to port B.
module imem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   adra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  input  logic                    enb,
  input  logic [ADDR_WIDTH-1:0]   adrb,
  output logic [DATA_WIDTH-1:0]   doutb
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    ready_q;

  // Qualified accesses: both ports are dead until the clear sequence is done.
  logic                    acc_a;
  logic                    acc_b;

  // Single write port into the array, shared by the clear engine and port A.
  logic [NBYTES-1:0]       mem_wr_be;
  logic [ADDR_WIDTH-1:0]   mem_wr_adr;
  logic [DATA_WIDTH-1:0]   mem_wr_dat;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   rd_b_dat;

  assign acc_a = (state_q == ST_READY) && ena;
  assign acc_b = (state_q == ST_READY) && enb;
  assign ready = ready_q;

  // Next-state logic: walk the clear counter through every word, then settle in READY for good.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADR) begin
          // Hold the counter on the last word so it never wraps.
          state_d = ST_READY;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State, clear counter and ready flag; ready tracks the registered state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == ST_READY);
    end
  end

  // Write-port mux: the clear engine owns the array during CLEAR, port A afterwards.
  always_comb begin
    mem_wr_be  = '0;
    mem_wr_adr = adra;
    mem_wr_dat = dina;
    if (state_q == ST_CLEAR) begin
      mem_wr_be  = '1;
      mem_wr_adr = clr_cnt_q;
      mem_wr_dat = '0;
    end else if (ena) begin
      mem_wr_be  = wea;
    end
  end

  // Byte-masked array write; the array itself carries no reset, the clear engine zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_wr_be[i]) begin
        mem[mem_wr_adr][8*i +: 8] <= mem_wr_dat[8*i +: 8];
      end
    end
  end

`ifdef IMEM_BANK_FWD_EN
  // Port B read data with same-cycle port A write bytes merged over the stored word.
  always_comb begin
    rd_b_dat = mem[adrb];
    if (acc_a && (adra == adrb)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wea[i]) begin
          rd_b_dat[8*i +: 8] = dina[8*i +: 8];
        end
      end
    end
  end
`else
  // Port B sees the stored word only, so a same-cycle port A write is not yet visible.
  assign rd_b_dat = mem[adrb];
`endif

  // Port A output register: read-first, captures the word before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta <= '0;
    end else if (acc_a) begin
      douta <= mem[adra];
    end
  end

  // Port B output register: loads on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doutb <= '0;
    end else if (acc_b) begin
      doutb <= rd_b_dat;
    end
  end

endmodule

// File: tb/tb_imem_bank.sv
// Directed bench for imem_bank at ADDR_WIDTH=4, DATA_WIDTH=32.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants; IMEM_BANK_FWD_EN selects the collision expectations.
module tb_imem_bank;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        ena;
  logic [3:0]  wea;
  logic [3:0]  adra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        enb;
  logic [3:0]  adrb;
  logic [31:0] doutb;

  int total;
  int bad;

  imem_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ready(ready),
    .ena  (ena),
    .wea  (wea),
    .adra (adra),
    .dina (dina),
    .douta(douta),
    .enb  (enb),
    .adrb (adrb),
    .doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks ready is low for 16 cycles and high on the 17th after reset release.
  // With inject set, a full-word port A write to address 2 is attempted mid-clear.
  task automatic run_clear(input bit inject);
    chk("ready_cycle1", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      if (inject && k >= 8 && k <= 10) begin
        ena  = 1'b1;
        wea  = 4'hF;
        adra = 4'd2;
        dina = 32'hFFFF_FFFF;
      end else begin
        ena  = 1'b0;
        wea  = 4'h0;
        dina = 32'h0;
      end
      tick();
      if (k == 16) chk("ready_high", {31'd0, ready}, 32'd1);
      else         chk("ready_low", {31'd0, ready}, 32'd0);
    end
  endtask

  task automatic read_all_zero();
    ena = 1'b0;
    for (int a = 0; a < 16; a++) begin
      enb  = 1'b1;
      adrb = 4'(a);
      tick();
      chk("clear_word", doutb, 32'h0);
    end
    enb = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 4'h0;
    adra  = 4'd0;
    dina  = 32'h0;
    enb   = 1'b0;
    adrb  = 4'd0;

    // Reset state.
    tick();
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_douta", douta, 32'h0);
    chk("rst_doutb", doutb, 32'h0);

    // Initial clear sequence.
    rst = 1'b0;
    run_clear(1'b0);
    read_all_zero();

    // Full write then byte-masked write to address 3.
    ena = 1'b1; wea = 4'hF; adra = 4'd3; dina = 32'hDEAD_BEEF;
    tick();
    chk("a3_first_prewrite", douta, 32'h0);
    ena = 1'b1; wea = 4'h2; adra = 4'd3; dina = 32'h0000_AA00;
    tick();
    chk("a3_second_prewrite", douta, 32'hDEAD_BEEF);
    ena = 1'b0; wea = 4'h0; enb = 1'b1; adrb = 4'd3;
    tick();
    chk("b3_merged", doutb, 32'hDEAD_AAEF);
    chk("douta_hold", douta, 32'hDEAD_BEEF);

    // Port B holds while disabled even with a new address.
    enb = 1'b0; adrb = 4'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("doutb_hold", doutb, 32'hDEAD_AAEF);
    end

    // Same-address collision, full word.
    ena = 1'b1; wea = 4'hF; adra = 4'd5; dina = 32'h1234_5678;
    enb = 1'b1; adrb = 4'd5;
    tick();
`ifdef IMEM_BANK_FWD_EN
    chk("collide_full", doutb, 32'h1234_5678);
`else
    chk("collide_full", doutb, 32'h0);
`endif
    chk("a5_prewrite", douta, 32'h0);
    ena = 1'b0; wea = 4'h0;
    tick();
    chk("b5_after", doutb, 32'h1234_5678);

    // Same-address collision, single byte lane.
    ena = 1'b1; wea = 4'b0100; adra = 4'd5; dina = 32'h00AB_0000;
    enb = 1'b1; adrb = 4'd5;
    tick();
`ifdef IMEM_BANK_FWD_EN
    chk("collide_byte", doutb, 32'h12AB_5678);
`else
    chk("collide_byte", doutb, 32'h1234_5678);
`endif
    ena = 1'b0; wea = 4'h0;
    tick();
    chk("b5_byte_after", doutb, 32'h12AB_5678);

    // Read-first on port A.
    enb = 1'b0;
    ena = 1'b1; wea = 4'hF; adra = 4'd7; dina = 32'hCAFE_F00D;
    tick();
    chk("a7_prewrite", douta, 32'h0);
    wea = 4'h0; dina = 32'h0;
    tick();
    chk("a7_read", douta, 32'hCAFE_F00D);
    chk("doutb_hold2", doutb, 32'h12AB_5678);
    tick();
    chk("a7_reread", douta, 32'hCAFE_F00D);
    ena = 1'b0;

    // Asynchronous reset clears outputs without a clock edge.
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd0);
    chk("arst_douta", douta, 32'h0);
    chk("arst_doutb", doutb, 32'h0);
    tick();
    rst = 1'b0;

    // Reset pulse at clear cycle 8, then a write attempted during the restarted clear.
    for (int k = 0; k < 8; k++) tick();
    chk("midclear_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_clear(1'b1);
    chk("douta_ignored", douta, 32'h0);
    read_all_zero();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_bank.md
IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word-address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ready  output  1  high when the clear sequence is done and accesses are accepted.
REQ-006 SHALL have port ena  input  1  port A access enable.
REQ-007 SHALL have port wea  input  DATA_WIDTH/8  port A byte write enables; bit i covers bits [8i+7:8i].
REQ-008 SHALL have port adra  input  ADDR_WIDTH  port A word address.
REQ-009 SHALL have port dina  input  DATA_WIDTH  port A write data.
REQ-010 SHALL have port douta  output  DATA_WIDTH  port A registered read data.
REQ-011 SHALL have port enb  input  1  port B (read-only) enable.
REQ-012 SHALL have port adrb  input  ADDR_WIDTH  port B word address.
REQ-013 SHALL have port doutb  output  DATA_WIDTH  port B registered read data.

Function
REQ-014 SHALL use a two-state FSM: CLEAR and READY; reset forces CLEAR with clear counter 0.
REQ-015 In CLEAR, SHALL write all-zero to word[counter] each cycle, increment counter, and ignore ena/enb.
REQ-016 SHALL move CLEAR->READY on the cycle the counter reaches 2^ADDR_WIDTH-1; ready asserts the following cycle; clear takes exactly 2^ADDR_WIDTH cycles.
REQ-017 ready SHALL be a registered output equal to (state == READY); READY has no exit except reset.
REQ-018 In READY with ena=1, SHALL write each byte of word[adra] whose wea bit is 1 from dina; bytes with wea bit 0 unchanged.
REQ-019 In READY with ena=1, douta SHALL load the pre-write contents of word[adra] one cycle later (read-first), regardless of wea.
REQ-020 In READY with enb=1, doutb SHALL load word[adrb] one cycle later.
REQ-021 With the respective enable low or ready low, douta/doutb SHALL hold their last value.
REQ-022 Same-cycle port A write and port B read of the same address: behaviour per REQ-026.
REQ-023 Address width is exact; no out-of-range condition exists; counter wrap beyond depth SHALL never occur.

Reset
REQ-024 On rst assertion, SHALL immediately set douta=0, doutb=0, ready=0, state=CLEAR, counter=0; memory array not reset directly.
REQ-025 Reset asserted mid-clear or in READY SHALL restart the full clear sequence after deassertion.

Configuration
REQ-026 Macro IMEM_BANK_FWD_EN: defined -> same-address collision in REQ-022 returns to doutb the old word merged with newly written bytes per wea; undefined -> doutb returns the old (pre-write) word.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32)
REQ-027 Release rst, sample ready -> ready low 16 cycles, high on cycle 17; then read every address on B -> all 32'h0.
REQ-028 ena=1, wea=4'hF, adra=3, dina=32'hDEADBEEF; next ena=1, wea=4'h2, adra=3, dina=32'h0000AA00; then read B adr 3 -> 32'hDEADAAEF.
REQ-029 Write 32'h12345678 to adr 5 while enb=1, adrb=5 same cycle -> doutb=32'h0 without IMEM_BANK_FWD_EN, 32'h12345678 with it; following read -> 32'h12345678.
REQ-030 Write adr 7 with wea=4'hF, dina=32'hCAFEF00D -> douta shows pre-write 32'h0 next cycle; repeat read -> 32'hCAFEF00D.
REQ-031 Assert rst for 1 cycle at clear cycle 8, then issue write during clear -> ready low 16 cycles after release, write ignored, all words 32'h0.
REQ-032 enb=0 for 3 cycles after reading 32'hDEADAAEF with adrb changed -> doutb holds 32'hDEADAAEF.
